// File: rtl/cam_frame_capture.sv
// cam_frame_capture: camera-bus frame grabber with window crop and word packing.
// Optional decimation port enabled by defining CAMCAP_DECIMATE_EN.
module cam_frame_capture #(
  parameter int BYTES_PER_PIXEL = 2,
  parameter int PIXELS_PER_WORD = 2,
  parameter int LINE_PIXELS     = 640,
  parameter int FRAME_LINES     = 480,
  parameter int WIN_ROW_START   = 0,
  parameter int WIN_ROWS        = 480,
  parameter int WIN_COL_START   = 0,
  parameter int WIN_COLS        = 640,
  localparam int OUT_W          = 8 * BYTES_PER_PIXEL * PIXELS_PER_WORD
) (
  input  logic             pclk,
  input  logic             reset,
  input  logic             href,
  input  logic             vsync,
  input  logic [7:0]       d,
  input  logic             shutter,
  input  logic             continuous,
  input  logic             fifo_full,
`ifdef CAMCAP_DECIMATE_EN
  input  logic             decim,
`endif
  output logic             wr_en,
  output logic [OUT_W-1:0] wr_data,
  output logic             busy,
  output logic             frame_done,
  output logic             short_frame,
  output logic             overflow
);
  localparam int WB      = BYTES_PER_PIXEL * PIXELS_PER_WORD;
  localparam int BMAX    = LINE_PIXELS * BYTES_PER_PIXEL;
  localparam int ROW_END = WIN_ROW_START + WIN_ROWS;
  localparam int COL_END = WIN_COL_START + WIN_COLS;
  localparam int BCW     = $clog2(BMAX + 1);
  localparam int LCW     = $clog2(FRAME_LINES + 1);
  localparam int WBW     = $clog2(WB + 1);
  localparam logic [1:0] IDLE = 2'd0, WAIT_SOF = 2'd1, CAPTURE = 2'd2, DONE = 2'd3;
  logic [1:0]       state_q, state_d;
  logic [BCW-1:0]   byte_cnt_q, byte_cnt_d;
  logic [LCW-1:0]   line_cnt_q, line_cnt_d;
  logic [WBW-1:0]   wbyte_q, wbyte_d;
  logic [OUT_W-1:0] pack_q, pack_d, wr_data_q, wr_data_d;
  logic             wr_en_q, wr_en_d, short_q, short_d, ovf_q, ovf_d;
  logic             vsync_q, href_q, decim_q, enter_wait, store;
  int               pix, row, pos;
`ifdef CAMCAP_DECIMATE_EN
  always_ff @(posedge pclk) decim_q <= reset ? 1'b0 : enter_wait ? decim : decim_q;
`else
  assign decim_q = 1'b0;
`endif
  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    line_cnt_d = line_cnt_q;
    wbyte_d    = wbyte_q;
    pack_d     = pack_q;
    wr_en_d    = 1'b0;
    wr_data_d  = wr_data_q;
    short_d    = short_q;
    ovf_d      = ovf_q;
    pix        = int'(byte_cnt_q) / BYTES_PER_PIXEL;
    row        = int'(line_cnt_q);
    // first byte of a pixel is its most significant; pixel slots fill from the LSB
    pos        = (int'(wbyte_q) / BYTES_PER_PIXEL) * BYTES_PER_PIXEL
               + BYTES_PER_PIXEL - 1 - int'(wbyte_q) % BYTES_PER_PIXEL;
    store      = state_q == CAPTURE && href && byte_cnt_q < BCW'(BMAX)
               && row >= WIN_ROW_START && row < ROW_END
               && pix >= WIN_COL_START && pix < COL_END
               && (!decim_q || (pix % 2 == 0 && row % 2 == 0));
    if (state_q == IDLE && (shutter || continuous))
      state_d = WAIT_SOF;
    if (state_q == WAIT_SOF) begin
      byte_cnt_d = '0;
      line_cnt_d = '0;
      wbyte_d    = '0;
      if (vsync_q && !vsync)
        state_d = CAPTURE;
    end
    if (state_q == CAPTURE) begin
      if (href && byte_cnt_q != BCW'(BMAX))
        byte_cnt_d = byte_cnt_q + BCW'(1);
      if (store) begin
        for (int i = 0; i < WB; i++)
          if (i == pos)
            pack_d[i*8 +: 8] = d;
        wbyte_d = wbyte_q == WBW'(WB - 1) ? '0 : wbyte_q + WBW'(1);
        if (wbyte_q == WBW'(WB - 1)) begin
          ovf_d     = ovf_q | fifo_full;
          wr_en_d   = !fifo_full;
          wr_data_d = fifo_full ? wr_data_q : pack_d;
        end
      end
      if (href_q && !href) begin
        line_cnt_d = line_cnt_q + LCW'(1);
        byte_cnt_d = '0;
        if (line_cnt_q + LCW'(1) == LCW'(ROW_END))
          state_d = DONE;
      end
      // a vsync rise mid-window wins over everything and drops any partial word
      if (vsync && !vsync_q) begin
        state_d = DONE;
        short_d = 1'b1;
        wbyte_d = '0;
      end
    end
    if (state_q == DONE)
      state_d = continuous ? WAIT_SOF : IDLE;
    enter_wait = state_d == WAIT_SOF && state_q != WAIT_SOF;
    if (enter_wait) begin
      short_d = 1'b0;
      ovf_d   = 1'b0;
    end
  end
  always_ff @(posedge pclk) begin
    if (reset) begin
      state_q    <= IDLE;
      byte_cnt_q <= '0;
      line_cnt_q <= '0;
      wbyte_q    <= '0;
      pack_q     <= '0;
      wr_en_q    <= 1'b0;
      wr_data_q  <= '0;
      short_q    <= 1'b0;
      ovf_q      <= 1'b0;
      vsync_q    <= 1'b0;
      href_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      line_cnt_q <= line_cnt_d;
      wbyte_q    <= wbyte_d;
      pack_q     <= pack_d;
      wr_en_q    <= wr_en_d;
      wr_data_q  <= wr_data_d;
      short_q    <= short_d;
      ovf_q      <= ovf_d;
      vsync_q    <= vsync;
      href_q     <= href;
    end
  end
  assign wr_en       = wr_en_q;
  assign wr_data     = wr_data_q;
  assign busy        = state_q != IDLE;
  assign frame_done  = state_q == DONE;
  assign short_frame = short_q;
  assign overflow    = ovf_q;
endmodule

// File: tb/tb_cam_frame_capture.sv
// tb_cam_frame_capture: table-driven scenarios with a word scoreboard for cam_frame_capture.
module tb_cam_frame_capture;
  logic        pclk = 1'b0, reset = 1'b1, href = 1'b0, vsync = 1'b1;
  logic [7:0]  d = '0;
  logic        shutter = 1'b0, continuous = 1'b0, fifo_full = 1'b0;
  logic        wr_en, busy, frame_done, short_frame, overflow;
  logic [31:0] wr_data;
  bit          dec_mode = 1'b0;
`ifdef CAMCAP_DECIMATE_EN
  logic        decim = 1'b0;
`endif
  int          total = 0, bad = 0, strobes = 0, dones = 0, busy_drops = 0;
  bit          watch_busy = 1'b0;
  logic [31:0] exp_q[$];

  cam_frame_capture #(
    .BYTES_PER_PIXEL(2), .PIXELS_PER_WORD(2), .LINE_PIXELS(8), .FRAME_LINES(6),
    .WIN_ROW_START(2), .WIN_ROWS(2), .WIN_COL_START(2), .WIN_COLS(4)
  ) dut (
    .pclk(pclk), .reset(reset), .href(href), .vsync(vsync), .d(d),
    .shutter(shutter), .continuous(continuous), .fifo_full(fifo_full),
`ifdef CAMCAP_DECIMATE_EN
    .decim(decim),
`endif
    .wr_en(wr_en), .wr_data(wr_data), .busy(busy), .frame_done(frame_done),
    .short_frame(short_frame), .overflow(overflow)
  );

  always #5 pclk = ~pclk;

  always @(negedge pclk) begin
    if (wr_en) begin
      strobes++;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL word: unexpected strobe data=%h", wr_data);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        if (wr_data !== e) begin
          bad++;
          $display("FAIL word: got %h expected %h", wr_data, e);
        end
      end
    end
    if (frame_done) dones++;
    if (watch_busy && !busy) busy_drops++;
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // drives one camera frame; pushes each word the window/packing rules say should appear
  task automatic run_frame(input int drop, input int last_line, input bit stop_cont, input int abort_bytes);
    logic [7:0]  hb;
    logic [15:0] p0, px;
    int pc = 0, widx = 0, nst = 0;
    bit st, comp;
    hb = '0;
    p0 = '0;
    vsync = 1'b1;
    @(negedge pclk);
    vsync = 1'b0;
    @(negedge pclk);
    if (stop_cont) begin
      watch_busy = 1'b0;
      continuous = 1'b0;
    end
    @(negedge pclk);
    for (int l = 0; l <= last_line; l++) begin
      for (int b = 0; b < 16; b++) begin
        href = 1'b1;
        d = {4'(l), 4'(b)};
        st = l >= 2 && l < 4 && b / 2 >= 2 && b / 2 < 6 &&
             (!dec_mode || ((b / 2) % 2 == 0 && l % 2 == 0));
        comp = 1'b0;
        if (st) begin
          if (b % 2 == 0) hb = d;
          else begin
            px = {hb, d};
            if (pc == 0) p0 = px;
            else begin
              comp = 1'b1;
              if (widx != drop) exp_q.push_back({px, p0});
              widx++;
            end
            pc = 1 - pc;
          end
          nst++;
        end
        fifo_full = comp && (widx - 1 == drop);
        @(negedge pclk);
        if (abort_bytes > 0 && nst == abort_bytes) begin
          href = 1'b0;
          fifo_full = 1'b0;
          return;
        end
      end
      href = 1'b0;
      fifo_full = 1'b0;
      @(negedge pclk);
      @(negedge pclk);
    end
    vsync = 1'b1;
  endtask

  typedef struct {
    bit cont; int frames; int drop; int last_line;
    int exp_strobes; int exp_dones; int exp_short; int exp_ovf;
  } vec_t;
  vec_t vecs[4];

  initial begin
    vecs[0] = '{1'b0, 1, -1, 5, 4, 1, 0, 0};
    vecs[1] = '{1'b1, 3, -1, 5, 12, 3, 0, 0};
    vecs[2] = '{1'b0, 1, 1, 5, 3, 1, 0, 1};
    vecs[3] = '{1'b0, 1, -1, 2, 2, 1, 1, 0};
    repeat (3) @(negedge pclk);
    chk("rst_wr_en", int'(wr_en), 0);
    chk("rst_wr_data", int'(wr_data), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_frame_done", int'(frame_done), 0);
    chk("rst_short", int'(short_frame), 0);
    chk("rst_overflow", int'(overflow), 0);
    reset = 1'b0;
    @(negedge pclk);
    foreach (vecs[i]) begin
      strobes = 0;
      dones = 0;
      busy_drops = 0;
      exp_q.delete();
      chk($sformatf("v%0d_idle_busy", i), int'(busy), 0);
      if (vecs[i].cont) continuous = 1'b1;
      else shutter = 1'b1;
      @(negedge pclk);
      shutter = 1'b0;
      chk($sformatf("v%0d_arm_busy", i), int'(busy), 1);
      watch_busy = vecs[i].cont;
      for (int f = 0; f < vecs[i].frames; f++)
        run_frame(vecs[i].drop, vecs[i].last_line, vecs[i].cont && f == vecs[i].frames - 1, 0);
      repeat (6) @(negedge pclk);
      chk($sformatf("v%0d_strobes", i), strobes, vecs[i].exp_strobes);
      chk($sformatf("v%0d_dones", i), dones, vecs[i].exp_dones);
      chk($sformatf("v%0d_short", i), int'(short_frame), vecs[i].exp_short);
      chk($sformatf("v%0d_overflow", i), int'(overflow), vecs[i].exp_ovf);
      chk($sformatf("v%0d_busy_end", i), int'(busy), 0);
      chk($sformatf("v%0d_pending", i), exp_q.size(), 0);
      chk($sformatf("v%0d_busy_drops", i), busy_drops, 0);
    end
    // overflow left set by a dropped word must clear when the next capture arms
    exp_q.delete();
    run_frame(-1, 0, 1'b0, 0);
    shutter = 1'b1;
    @(negedge pclk);
    shutter = 1'b0;
    strobes = 0;
    run_frame(1, 5, 1'b0, 0);
    repeat (4) @(negedge pclk);
    chk("ovf_set", int'(overflow), 1);
    shutter = 1'b1;
    @(negedge pclk);
    shutter = 1'b0;
    chk("ovf_clear_on_arm", int'(overflow), 0);
    // reset mid-capture after three bytes of word 0
    run_frame(-1, 5, 1'b0, 3);
    reset = 1'b1;
    @(negedge pclk);
    chk("mid_rst_wr_en", int'(wr_en), 0);
    chk("mid_rst_wr_data", int'(wr_data), 0);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_frame_done", int'(frame_done), 0);
    chk("mid_rst_short", int'(short_frame), 0);
    chk("mid_rst_overflow", int'(overflow), 0);
    reset = 1'b0;
    vsync = 1'b1;
    exp_q.delete();
    strobes = 0;
    @(negedge pclk);
    shutter = 1'b1;
    @(negedge pclk);
    shutter = 1'b0;
    chk("post_rst_first_word_model", int'(exp_q.size()), 0);
    run_frame(-1, 5, 1'b0, 0);
    repeat (4) @(negedge pclk);
    chk("post_rst_strobes", strobes, 4);
    chk("post_rst_pending", exp_q.size(), 0);
`ifdef CAMCAP_DECIMATE_EN
    dec_mode = 1'b1;
    decim = 1'b1;
    strobes = 0;
    shutter = 1'b1;
    @(negedge pclk);
    shutter = 1'b0;
    decim = 1'b0;
    run_frame(-1, 5, 1'b0, 0);
    repeat (4) @(negedge pclk);
    chk("decim_strobes", strobes, 1);
    chk("decim_pending", exp_q.size(), 0);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/cam_frame_capture.md
# cam_frame_capture

Parametrised frame-capture front end for the 8-bit parallel camera bus (pclk/href/vsync/d). It sits between the camera pins and the frame FIFO. On a shutter request it captures one frame, or runs continuously, and crops to a configurable window. Pixels are packed into FIFO words of configurable width, and FIFO back-pressure is reported as overflow rather than stalling the camera.

## Interface
Parameters:
- BYTES_PER_PIXEL, 2, bytes per pixel on d (1..4)
- PIXELS_PER_WORD, 2, pixels packed per FIFO word (1..8); OUT_W = 8*BYTES_PER_PIXEL*PIXELS_PER_WORD
- LINE_PIXELS, 640, source pixels per line
- FRAME_LINES, 480, source lines per frame
- WIN_ROW_START, 0, first captured line; WIN_ROWS, 480, captured line count
- WIN_COL_START, 0, first captured pixel; WIN_COLS, 640, captured pixel count; WIN_COLS % PIXELS_PER_WORD == 0, window must lie inside the frame

Ports:
- reset, synchronous, active-high; clock pclk
- pclk  in  1  camera pixel clock; all logic on posedge
- reset  in  1  see above
- href  in  1  line-valid; byte sampled on every posedge with href=1
- vsync  in  1  frame sync; high between frames
- d  in  8  pixel byte
- shutter  in  1  debounced capture request, level, active-high
- continuous  in  1  1 = re-arm after each frame
- fifo_full  in  1  FIFO cannot accept a word this cycle
- wr_en  out  1  one-cycle word strobe
- wr_data  out  OUT_W  packed word
- busy  out  1  state != IDLE
- frame_done  out  1  one-cycle pulse at end of capture
- short_frame  out  1  sticky; last frame ended early
- overflow  out  1  sticky; a word was dropped

## Operation
- States: IDLE, WAIT_SOF, CAPTURE, DONE.
- IDLE: go to WAIT_SOF when shutter=1 or continuous=1.
- WAIT_SOF: go to CAPTURE on the vsync falling edge (vsync_q=1, vsync=0). Line and byte counters clear on entry. short_frame and overflow clear on entry.
- CAPTURE: byte_cnt increments per sampled byte, saturating at LINE_PIXELS*BYTES_PER_PIXEL; extra bytes are ignored. On the href falling edge, line_cnt increments and byte_cnt clears.
- Pixel index = byte_cnt / BYTES_PER_PIXEL. A byte is stored only if line_cnt is in [WIN_ROW_START, WIN_ROW_START+WIN_ROWS) and the pixel index is in [WIN_COL_START, WIN_COL_START+WIN_COLS).
- Packing: pixel slot k occupies wr_data[(k+1)*PW-1 : k*PW], with PW = 8*BYTES_PER_PIXEL. The first received pixel of a word goes to slot 0. Within a pixel, the first received byte is the most significant.
- CAPTURE → DONE when line_cnt reaches WIN_ROW_START+WIN_ROWS. The remainder of the frame is ignored.
- CAPTURE → DONE with short_frame set if vsync rises first. Any partial word is discarded.
- DONE lasts one cycle and pulses frame_done. Next state is WAIT_SOF if continuous=1, else IDLE.
- shutter is ignored outside IDLE.
- Overflow: if a word completes while fifo_full=1, wr_en stays 0 and the word is dropped. overflow is set and packing continues with the next word.
- Reset at any time: state IDLE, counters 0, partial word discarded, all outputs 0.

## Timing
- Reset values: wr_en=0, wr_data=0, busy=0, frame_done=0, short_frame=0, overflow=0.
- wr_en/wr_data are registered on the same posedge that samples the word's last byte. They are visible for exactly one cycle after that edge.
- wr_data holds its value between strobes.
- Pixel bytes reach the FIFO one pclk after sampling.
- shutter-to-busy latency: 1 cycle.
- frame_done is high in the cycle after the final href falling edge of the window.
- vsync rising and href=1 on the same edge: the byte is sampled and the frame ends short. vsync wins.
- fifo_full is sampled on the same edge as the word completes.

## Configuration
- CAMCAP_DECIMATE_EN defined: adds input port decim (1 bit).
  - With decim=1, only even pixel indices on even line_cnt values are stored. Window parameters stay in source coordinates. Output is a quarter of the words.
  - Requires WIN_COLS % (2*PIXELS_PER_WORD) == 0.
  - decim is sampled on entry to WAIT_SOF and held for the frame.
- Not defined: port absent; full resolution always.

## Test plan
Test parameters: LINE_PIXELS=8, FRAME_LINES=6, BYTES_PER_PIXEL=2, PIXELS_PER_WORD=2, WIN_ROW_START=2, WIN_ROWS=2, WIN_COL_START=2, WIN_COLS=4; byte value = {line[3:0], byte_cnt[3:0]}.
- Single shot, shutter pulse then one frame → exactly 4 wr_en strobes. Word 0 = 32'h2627_2425. frame_done pulses once, then busy=0.
- continuous=1 for 3 frames → 12 strobes and 3 frame_done pulses. busy stays 1 throughout.
- fifo_full=1 on word 1 only → 3 strobes, word 1 missing, overflow=1. overflow clears on the next WAIT_SOF entry.
- vsync rises after line 2 → 2 strobes, frame_done pulses, short_frame=1.
- reset mid-CAPTURE after 3 bytes of word 0 → all outputs 0 next cycle. A following capture yields word 0 = 32'h2627_2425 (no stale bytes).
- CAMCAP_DECIMATE_EN, decim=1, WIN_COLS=4 → 1 strobe: line 2, pixels 2 and 4, value 32'h2829_2425.
